// File: rtl/instruction_dispatcher_if.sv
// Instruction push channel: valid/ready handshake carrying one packed instruction.
interface instruction_dispatcher_if #(
    parameter int unsigned INST_BITS = 148
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [INST_BITS-1:0] in_inst;

    modport master (output in_valid, output in_inst, input in_ready);
    modport slave  (input in_valid, input in_inst, output in_ready);
endinterface

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: queues instructions and presents each to the control
// unit for an opcode-dependent number of cycles.
// Optional feature: define DISPATCH_ISSUE_CNT_EN to enable the 32-bit issue counter.
module instruction_dispatcher #(
    parameter int unsigned OPCODE_BITS       = 4,
    parameter int unsigned ADDR_BITS         = 8,
    parameter int unsigned OPERAND_BITS      = 128,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned IDLE_CYCLE        = 1,
    parameter int unsigned WRITE_CYCLE       = 1,
    parameter int unsigned LOAD_DATA_CYCLE   = 2,
    parameter int unsigned LOAD_WEIGHT_CYCLE = 2,
    parameter int unsigned MAT_MUL_CYCLE     = 32,
    localparam int unsigned INST_BITS = OPCODE_BITS + 2 * ADDR_BITS + OPERAND_BITS,
    localparam int unsigned PTR_BITS  = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_BITS  = PTR_BITS + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      flush,
    instruction_dispatcher_if.slave   push_if,
    output logic [INST_BITS-1:0]      instruction,
    output logic                      issue_start,
    output logic                      busy,
    output logic [CNT_BITS-1:0]       fifo_count,
    output logic [31:0]               issue_cnt
);
    localparam int unsigned HOLD_BITS = 32;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    logic [INST_BITS-1:0] mem [FIFO_DEPTH];

    state_t               state_q, state_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic [INST_BITS-1:0] instr_q, instr_d;
    logic                 issue_start_q, issue_start_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_q, in_ready_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 push_c, pop_c;
    logic [INST_BITS-1:0] head_c;
`ifdef DISPATCH_ISSUE_CNT_EN
    logic [31:0]          issue_cnt_q, issue_cnt_d;
`endif

    // Number of cycles an opcode occupies the instruction output.
    function automatic logic [HOLD_BITS-1:0] hold_len(input logic [OPCODE_BITS-1:0] op);
        logic [HOLD_BITS-1:0] n;
        case (op)
            OPCODE_BITS'(1), OPCODE_BITS'(2): n = HOLD_BITS'(WRITE_CYCLE);
            OPCODE_BITS'(3):                  n = HOLD_BITS'(LOAD_DATA_CYCLE);
            OPCODE_BITS'(4):                  n = HOLD_BITS'(LOAD_WEIGHT_CYCLE);
            OPCODE_BITS'(5), OPCODE_BITS'(6): n = HOLD_BITS'(MAT_MUL_CYCLE);
            default:                          n = HOLD_BITS'(IDLE_CYCLE);
        endcase
        return n;
    endfunction

    assign head_c = mem[rd_ptr_q];

    // Next-state: queue bookkeeping, pop decision and hold countdown.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        instr_d       = instr_q;
        issue_start_d = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
`ifdef DISPATCH_ISSUE_CNT_EN
        issue_cnt_d   = issue_cnt_q;
`endif
        // A full queue refuses pushes even if a pop frees a slot on the same edge.
        push_c = push_if.in_valid && in_ready_q && !flush;
        pop_c  = en && (count_q != '0) && !flush &&
                 ((state_q == S_IDLE) || (hold_q == '0));

        if (flush) begin
            state_d  = S_IDLE;
            hold_d   = '0;
            instr_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            end
            if (pop_c) begin
                rd_ptr_d      = rd_ptr_q + PTR_BITS'(1);
                instr_d       = head_c;
                hold_d        = hold_len(head_c[INST_BITS-1 -: OPCODE_BITS]) - HOLD_BITS'(1);
                state_d       = S_HOLD;
                issue_start_d = 1'b1;
`ifdef DISPATCH_ISSUE_CNT_EN
                issue_cnt_d   = issue_cnt_q + 32'd1;
`endif
            end else if (state_q == S_HOLD) begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_BITS'(1);
                end else begin
                    state_d = S_IDLE;
                    instr_d = '0;
                end
            end
            count_d = count_q + CNT_BITS'(push_c) - CNT_BITS'(pop_c);
        end

        in_ready_d = (count_d < CNT_BITS'(FIFO_DEPTH));
        busy_d     = (count_d != '0) || (state_d == S_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            instr_q       <= '0;
            issue_start_q <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            instr_q       <= instr_d;
            issue_start_q <= issue_start_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr_q] <= push_if.in_inst;
        end
    end

`ifdef DISPATCH_ISSUE_CNT_EN
    // Free-running issue counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end
    assign issue_cnt = issue_cnt_q;
`else
    assign issue_cnt = '0;
`endif

    assign push_if.in_ready = in_ready_q;
    assign instruction      = instr_q;
    assign issue_start      = issue_start_q;
    assign busy             = busy_q;
    assign fifo_count       = count_q;
endmodule

// File: tb/tb_instruction_dispatcher.sv
// Scoreboard bench for instruction_dispatcher: the driver queues expected issues,
// a negedge monitor checks issue timing, hold length and instruction contents.
module tb_instruction_dispatcher;
    localparam int unsigned IB = 148;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [IB-1:0] instruction;
    logic          issue_start;
    logic          busy;
    logic [4:0]    fifo_count;
    logic [31:0]   issue_cnt;

    instruction_dispatcher_if #(.INST_BITS(IB)) pif ();

    instruction_dispatcher dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .flush       (flush),
        .push_if     (pif),
        .instruction (instruction),
        .issue_start (issue_start),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IB-1:0] inst;
        int            n;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic en_e = 1'b0;
    logic flush_e = 1'b0;

`ifdef DISPATCH_ISSUE_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    task automatic check(input string nm, input logic [IB-1:0] act, input logic [IB-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [IB-1:0] mk(input int op, input int a, input int b, input int opnd);
        return {4'(op), 8'(a), 8'(b), 128'(opnd)};
    endfunction

    task automatic push(input logic [IB-1:0] inst, input int n, output bit acc);
        exp_t e;
        pif.in_valid = 1'b1;
        pif.in_inst  = inst;
        acc = pif.in_ready && !flush;
        @(posedge clk);
        #1;
        pif.in_valid = 1'b0;
        if (acc) begin
            e.inst = inst;
            e.n    = n;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
    endtask

    // Edge-sampled view of the control inputs the DUT saw.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_e    <= en;
        flush_e <= flush;
    end

    // Monitor: compares every cycle against the scoreboard.
    initial begin
        int            rem;
        logic [IB-1:0] cur;
        logic          exp_start;
        exp_t          e;
        rem = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rem = 0;
            end else if (flush_e) begin
                check("flush_inst", instruction, '0);
                check("flush_count", IB'(fifo_count), '0);
                check("flush_busy", IB'(busy), '0);
                check("flush_start", IB'(issue_start), '0);
                rem = 0;
            end else begin
                exp_start = (rem == 0) && en_e && (exp_q.size() > 0) && (exp_q[0].acc < cyc);
                check("issue_start", IB'(issue_start), IB'(exp_start));
                if (issue_start && exp_start) begin
                    e = exp_q.pop_front();
                    check("issue_inst", instruction, e.inst);
                    cur = e.inst;
                    rem = e.n - 1;
                end else if (rem > 0) begin
                    check("hold_inst", instruction, cur);
                    rem--;
                end else begin
                    check("idle_inst", instruction, '0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int acc_cnt;
        int ops[4] = '{1, 9, 4, 2};
        int ns[4]  = '{1, 1, 2, 1};
        pif.in_valid = 1'b0;
        pif.in_inst  = '0;

        // Reset values
        #1;
        check("rst_inst", instruction, '0);
        check("rst_start", IB'(issue_start), '0);
        check("rst_busy", IB'(busy), '0);
        check("rst_count", IB'(fifo_count), '0);
        check("rst_issue_cnt", IB'(issue_cnt), '0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_in_ready", IB'(pif.in_ready), IB'(1));

        // Single LOAD_DATA, addrb=3, held 2 cycles
        en = 1'b1;
        push(mk(3, 0, 3, 0), 2, acc);
        @(posedge clk);
        #1;
        check("ld_latency_start", IB'(issue_start), IB'(1));
        check("ld_latency_inst", instruction, mk(3, 0, 3, 0));
        repeat (3) @(posedge clk);
        #1;
        check("ld_done_busy", IB'(busy), '0);

        // MAT_MUL then LOAD_DATA back-to-back
        push(mk(5, 1, 2, 32'hABCD), 32, acc);
        push(mk(3, 4, 5, 32'h1234), 2, acc);
        repeat (40) @(posedge clk);
        #1;
        check("mm_done_busy", IB'(busy), '0);

        // Fill 17 with en=0: 16 accepted, pointers wrap on drain
        en = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            push(mk(ops[i % 4], i, 255 - i, 32'h100 + i), ns[i % 4], acc);
            if (acc) acc_cnt++;
        end
        check("fill_accepted", IB'(acc_cnt), IB'(16));
        check("fill_in_ready", IB'(pif.in_ready), '0);
        check("fill_count", IB'(fifo_count), IB'(16));
        en = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("drain_count", IB'(fifo_count), '0);
        check("drain_busy", IB'(busy), '0);

        // Flush during 10th MAT_MUL cycle with 3 queued; simultaneous push discarded
        push(mk(5, 7, 7, 32'h55), 32, acc);
        for (int i = 0; i < 3; i++) push(mk(3, i, i, 32'h77), 2, acc);
        repeat (7) @(posedge clk);
        #1;
        check("pre_flush_count", IB'(fifo_count), IB'(3));
        flush = 1'b1;
        pif.in_valid = 1'b1;
        pif.in_inst  = mk(1, 9, 9, 32'h99);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        pif.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_flush_count", IB'(fifo_count), '0);
        check("post_flush_busy", IB'(busy), '0);

        // Asynchronous reset mid-HOLD
        push(mk(6, 3, 3, 32'h66), 32, acc);
        repeat (5) @(posedge clk);
        check("pre_rst_issue_cnt", IB'(issue_cnt), IB'(21 * CNT_ON));
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_inst", instruction, '0);
        check("midrst_start", IB'(issue_start), '0);
        check("midrst_busy", IB'(busy), '0);
        check("midrst_count", IB'(fifo_count), '0);
        check("midrst_issue_cnt", IB'(issue_cnt), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_busy", IB'(busy), '0);
        check("no_resume_in_ready", IB'(pif.in_ready), IB'(1));

        // Five issues, then reset clears the counter
        for (int i = 0; i < 5; i++) push(mk(1, i, i, 32'h500 + i), 1, acc);
        repeat (5) @(posedge clk);
        #1;
        check("issue_cnt_5", IB'(issue_cnt), IB'(5 * CNT_ON));
        reset_n = 1'b0;
        #1;
        check("issue_cnt_rst", IB'(issue_cnt), '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instruction_dispatcher.md
INSTRUCTION_DISPATCHER -- requirements
Module: instruction_dispatcher

Interface
REQ-001 Parameter OPCODE_BITS, default 4, opcode field width.
REQ-002 Parameter ADDR_BITS, default 8, width of each of ADDRA and ADDRB.
REQ-003 Parameter OPERAND_BITS, default 128, operand field width.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two, instruction queue entries.
REQ-005 Parameters IDLE_CYCLE=1, WRITE_CYCLE=1, LOAD_DATA_CYCLE=2, LOAD_WEIGHT_CYCLE=2, MAT_MUL_CYCLE=32; hold cycles per opcode class, each >=1.
REQ-006 Local INST_BITS = OPCODE_BITS+2*ADDR_BITS+OPERAND_BITS; field order MSB->LSB: OPCODE, ADDRA, ADDRB, OPERAND.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  dispatch enable; low blocks new pops only.
REQ-010 flush  input  1  synchronous queue clear and abort of current instruction.
REQ-011 in_valid / in_ready  input / output  1 / 1  push handshake; transfer when both high at the edge.
REQ-012 in_inst  input  INST_BITS  instruction to enqueue.
REQ-013 instruction  output  INST_BITS  registered instruction to the control unit.
REQ-014 issue_start  output  1  high for the first cycle of each dequeued instruction.
REQ-015 busy  output  1  queue non-empty or HOLD state.
REQ-016 fifo_count  output  log2(FIFO_DEPTH)+1  current queue occupancy.
REQ-017 issue_cnt  output  32  issued-instruction count (see Configuration).

Function
REQ-018 Opcodes: 0 IDLE, 1 WRITE_DATA, 2 WRITE_WEIGHT, 3 LOAD_DATA, 4 LOAD_WEIGHT, 5 MAT_MUL, 6 MAT_MUL_ACC; hold counts: IDLE_CYCLE, WRITE_CYCLE (1,2), LOAD_DATA_CYCLE, LOAD_WEIGHT_CYCLE, MAT_MUL_CYCLE (5,6); undefined opcodes use IDLE_CYCLE and are issued unchanged.
REQ-019 in_ready = (fifo_count < FIFO_DEPTH); push into a full queue is refused even when a pop occurs the same edge.
REQ-020 States: IDLE (instruction = all zeros) and HOLD (instruction = popped entry).
REQ-021 Pop condition: en=1, queue non-empty, flush=0, and (state IDLE, or state HOLD with hold counter = 0).
REQ-022 On pop: head loaded into instruction, hold counter = N-1 (N = opcode hold count), state HOLD, issue_start=1 next cycle.
REQ-023 Instruction accepted at edge k with empty queue and IDLE state appears on instruction after edge k+1.
REQ-024 Each instruction drives instruction for exactly N consecutive cycles; back-to-back pops leave no idle gap.
REQ-025 HOLD with counter 0 and no pop possible: next state IDLE, instruction = all zeros.
REQ-026 en falling during HOLD: current instruction completes its N cycles; no further pops.
REQ-027 flush=1: queue emptied, state IDLE, instruction zero after that edge; simultaneous push is discarded.
REQ-028 Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 reset_n low: immediately state IDLE, instruction=0, issue_start=0, busy=0, fifo_count=0, pointers=0, hold counter=0, issue_cnt=0; in_ready=1 after release; queue storage need not clear.
REQ-030 Reset asserted mid-HOLD aborts the instruction; no resumption after release.

Configuration
REQ-031 Macro DISPATCH_ISSUE_CNT_EN defined: issue_cnt increments by 1 per pop, wraps at 2^32, cleared only by reset.
REQ-032 Macro undefined: issue_cnt tied to 0, no counter logic.

Verification
REQ-033 Push LOAD_DATA addrb=3 into empty queue, en=1 -> instruction equals it 1 cycle after acceptance, held 2 cycles, then zero; issue_start one pulse.
REQ-034 Push MAT_MUL then LOAD_DATA back-to-back -> MAT_MUL held 32 cycles, LOAD_DATA next cycle held 2, no gap.
REQ-035 Push 17 instructions with en=0 -> 16 accepted, in_ready=0, fifo_count=16; raise en -> pointers wrap, all 16 issued in order.
REQ-036 flush during 10th cycle of MAT_MUL with 3 queued -> next cycle instruction=0, fifo_count=0, busy=0.
REQ-037 reset_n low mid-HOLD -> all outputs zero without a clock edge; with DISPATCH_ISSUE_CNT_EN, 5 issues then reset -> issue_cnt 5 then 0.
